bp_be_late_wb_queue: RTL and testbench
======================================

// Module: bp_be_late_wb_queue
// PURPOSE
// - Buffers late writebacks from the memory pipe (late loads, uncached/miss returns, PTW fills) and drains them
//   into the integer and FP register-file late write ports, each under its own valid/yumi handshake.
// - PTW results bypass storage and go straight to the page-table walker.
// - Sits directly downstream of the mem pipe's late_wb_pkt/late_wb_v outputs. Drives a credit-style full signal
//   that the issue logic uses to stall, because the mem pipe has no backpressure.
// PARAMETERS
// - els_p        4   queue depth in entries (power of two, >= 2)
// - data_width_p 66  rd_data width (dpath_width_gp)
// - addr_width_p 5   rd_addr width (reg_addr_width_gp)
// - full_slack_p 1   entries kept free when full_o asserts (covers one in-flight late op)
// PORTS
// - clk_i        in   1              clock; all state updates on the rising edge
// - reset_i      in   1              synchronous, active-high reset
// - ird_w_v_i    in   1              late packet targets the integer regfile
// - frd_w_v_i    in   1              late packet targets the FP regfile
// - ptw_w_v_i    in   1              late packet is a PTW result
// - rd_addr_i    in   addr_width_p   destination register
// - rd_data_i    in   data_width_p   writeback data
// - v_i          in   1              late packet valid (no ready; must be accepted)
// - full_o       out  1              count >= els_p-full_slack_p; issue stalls new mem ops
// - empty_o      out  1              no entries held
// - iwb_v_o      out  1              head entry is an int writeback
// - iwb_addr_o   out  addr_width_p   int writeback address
// - iwb_data_o   out  data_width_p   int writeback data
// - iwb_yumi_i   in   1              int port consumed head
// - fwb_v_o      out  1              head entry is an FP writeback
// - fwb_addr_o   out  addr_width_p   FP writeback address
// - fwb_data_o   out  data_width_p   FP writeback data
// - fwb_yumi_i   in   1              FP port consumed head
// - ptw_v_o      out  1              PTW result valid (combinational bypass)
// - ptw_data_o   out  data_width_p   PTW result data
// BEHAVIOUR
// - Reset: head/tail pointers 0, count 0. Outputs: empty_o=1, full_o=0, iwb_v_o=fwb_v_o=0.
//   ptw_v_o follows its inputs.
// - Enqueue: v_i & (ird_w_v_i|frd_w_v_i) writes {ird,frd,addr,data} at tail; tail increments mod els_p.
//   Entry is visible at the head no earlier than the next cycle (1-cycle minimum latency, no same-cycle bypass).
// - PTW: ptw_v_o = v_i & ptw_w_v_i, and ptw_data_o = rd_data_i, in the same cycle.
//   PTW packets are never enqueued. v_i with no target flag set is dropped.
// - Drain (in order): iwb_v_o = ~empty & head.ird; fwb_v_o = ~empty & head.frd.
//   Exactly one of the two is set per entry.
//   Dequeue on (iwb_v_o&iwb_yumi_i)|(fwb_v_o&fwb_yumi_i); head increments mod els_p.
//   Yumi without the matching valid is illegal (assertion).
// - Simultaneous enqueue+dequeue: count unchanged, both pointers advance. Enqueue when full (count==els_p)
//   is illegal (assertion); full_slack_p guarantees it never occurs when issue honours full_o.
// - Pointer wrap: els_p-1 -> 0. Count is $clog2(els_p)+1 bits wide. empty_o = (count==0).
// - No flush input: late writebacks belong to committed instructions and always drain.
// - Reset mid-operation discards all entries.
// - Outputs are driven from storage/pointers only; no combinational path yumi -> valid.
// STRUCTURE
// - bp_be_pkg: typedef bp_be_late_wb_entry_s {ird_w_v, frd_w_v, rd_addr, rd_data}; localparam for default depth.
// - Storage in one sub-module: bsg_mem_1r1w (els_p x entry width, async read).
//   Pointer/count control and port steering live in this module.
// TESTING
// - Reset, then idle -> empty_o=1, full_o=0, iwb_v_o=fwb_v_o=0.
// - Int pkt rd=5, data=0x1234, v_i=1 at cycle 0 -> iwb_v_o=1 at cycle 1 (addr 5, data 0x1234);
//   yumi at cycle 1 -> empty_o=1 at cycle 2.
// - Int rd=3, then FP rd=7, then int rd=9 (yumis held low) -> heads appear in order int3, fp7, int9.
//   FP yumi while head is int3 -> assertion fires.
// - Fill 3 entries with els_p=4, full_slack_p=1 -> full_o=1. Enqueue plus yumi in the same cycle
//   -> count stays 3, tail wraps 3->0.
// - PTW pkt data=0xABC -> ptw_v_o=1 with 0xABC that cycle; queue count unchanged, iwb_v_o stays 0.
// - Fill 2 entries, pulse reset_i -> next cycle empty_o=1 and no stale entry is presented.

Source files
------------

// File: rtl/bp_be_late_wb_queue_pkg.sv
// Shared types and default sizing for the backend late-writeback queue.
// Holds the entry layout and the depth and width defaults.
package bp_be_late_wb_queue_pkg;

    localparam int LWB_DEFAULT_ELS   = 4;
    localparam int LWB_DATA_W        = 66;
    localparam int LWB_ADDR_W        = 5;
    localparam int LWB_DEFAULT_SLACK = 1;

    // Default-width entry layout; the queue mirrors this ordering at its own parameter widths
    typedef struct packed {
        logic                  ird_w_v;
        logic                  frd_w_v;
        logic [LWB_ADDR_W-1:0] rd_addr;
        logic [LWB_DATA_W-1:0] rd_data;
    } bp_be_late_wb_entry_s;

endpackage

// File: rtl/bp_be_late_wb_queue_if.sv
// Late-writeback bundle: mem-pipe packet in, int/FP regfile drain ports and PTW bypass out.
// slave is the queue's view; master is the surrounding pipeline's view.
interface bp_be_late_wb_queue_if
    import bp_be_late_wb_queue_pkg::*;
#(
    parameter int data_width_p = LWB_DATA_W,
    parameter int addr_width_p = LWB_ADDR_W
);
    logic                    ird_w_v_i;
    logic                    frd_w_v_i;
    logic                    ptw_w_v_i;
    logic [addr_width_p-1:0] rd_addr_i;
    logic [data_width_p-1:0] rd_data_i;
    logic                    v_i;
    logic                    full_o;
    logic                    empty_o;
    logic                    iwb_v_o;
    logic [addr_width_p-1:0] iwb_addr_o;
    logic [data_width_p-1:0] iwb_data_o;
    logic                    iwb_yumi_i;
    logic                    fwb_v_o;
    logic [addr_width_p-1:0] fwb_addr_o;
    logic [data_width_p-1:0] fwb_data_o;
    logic                    fwb_yumi_i;
    logic                    ptw_v_o;
    logic [data_width_p-1:0] ptw_data_o;

    modport slave (
        input  ird_w_v_i, frd_w_v_i, ptw_w_v_i, rd_addr_i, rd_data_i, v_i,
        input  iwb_yumi_i, fwb_yumi_i,
        output full_o, empty_o,
        output iwb_v_o, iwb_addr_o, iwb_data_o,
        output fwb_v_o, fwb_addr_o, fwb_data_o,
        output ptw_v_o, ptw_data_o
    );

    modport master (
        output ird_w_v_i, frd_w_v_i, ptw_w_v_i, rd_addr_i, rd_data_i, v_i,
        output iwb_yumi_i, fwb_yumi_i,
        input  full_o, empty_o,
        input  iwb_v_o, iwb_addr_o, iwb_data_o,
        input  fwb_v_o, fwb_addr_o, fwb_data_o,
        input  ptw_v_o, ptw_data_o
    );

endinterface

// File: rtl/bp_be_late_wb_queue_mem.sv
// Entry storage: one synchronous write port, one asynchronous read port.
// Contents are not reset; validity is tracked by the owner's pointers.
module bp_be_late_wb_queue_mem #(
    parameter  int width_p = 73,
    parameter  int els_p   = 4,
    localparam int LG_ELS  = $clog2(els_p)
) (
    input  logic               clk_i,
    input  logic               w_v_i,
    input  logic [LG_ELS-1:0]  w_addr_i,
    input  logic [width_p-1:0] w_data_i,
    input  logic [LG_ELS-1:0]  r_addr_i,
    output logic [width_p-1:0] r_data_o
);

    logic [width_p-1:0] r_mem [els_p];

    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            r_mem[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = r_mem[r_addr_i];

endmodule

// File: rtl/bp_be_late_wb_queue.sv
// Late-writeback queue: buffers late int/FP results in order, steers the head to the
// matching regfile port and bypasses PTW results straight through.
module bp_be_late_wb_queue
    import bp_be_late_wb_queue_pkg::*;
#(
    parameter int els_p        = LWB_DEFAULT_ELS,
    parameter int data_width_p = LWB_DATA_W,
    parameter int addr_width_p = LWB_ADDR_W,
    parameter int full_slack_p = LWB_DEFAULT_SLACK
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    bp_be_late_wb_queue_if.slave        lwb
);

    localparam int LG_ELS  = $clog2(els_p);
    localparam int ENTRY_W = 2 + addr_width_p + data_width_p;

    localparam logic [LG_ELS-1:0] PTR_ONE     = LG_ELS'(1);
    localparam logic [LG_ELS:0]   CNT_ONE     = (LG_ELS + 1)'(1);
    localparam logic [LG_ELS:0]   CNT_FULL    = (LG_ELS + 1)'(els_p);
    localparam logic [LG_ELS:0]   FULL_THRESH = (LG_ELS + 1)'(els_p - full_slack_p);

    typedef struct packed {
        logic                    ird_w_v;
        logic                    frd_w_v;
        logic [addr_width_p-1:0] rd_addr;
        logic [data_width_p-1:0] rd_data;
    } entry_t;

    logic [LG_ELS-1:0] r_head;
    logic [LG_ELS-1:0] r_tail;
    logic [LG_ELS:0]   r_count;

    logic               w_enq;
    logic               w_deq;
    logic               w_empty;
    logic               w_iwb_v;
    logic               w_fwb_v;
    entry_t             w_wr_entry;
    entry_t             w_head;
    logic [ENTRY_W-1:0] w_rd_data;

    // PTW-only or flagless packets never occupy an entry
    assign w_enq   = lwb.v_i & (lwb.ird_w_v_i | lwb.frd_w_v_i);
    assign w_empty = (r_count == '0);
    assign w_iwb_v = ~w_empty & w_head.ird_w_v;
    assign w_fwb_v = ~w_empty & w_head.frd_w_v;
    assign w_deq   = (w_iwb_v & lwb.iwb_yumi_i) | (w_fwb_v & lwb.fwb_yumi_i);

    assign w_wr_entry = '{ird_w_v: lwb.ird_w_v_i,
                          frd_w_v: lwb.frd_w_v_i,
                          rd_addr: lwb.rd_addr_i,
                          rd_data: lwb.rd_data_i};

    bp_be_late_wb_queue_mem #(
        .width_p (ENTRY_W),
        .els_p   (els_p)
    ) u_mem (
        .clk_i    (clk_i),
        .w_v_i    (w_enq),
        .w_addr_i (r_tail),
        .w_data_i (w_wr_entry),
        .r_addr_i (r_head),
        .r_data_o (w_rd_data)
    );

    assign w_head = w_rd_data;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_tail <= r_tail + PTR_ONE;
            if (w_deq) r_head <= r_head + PTR_ONE;
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Slack below capacity lets one already-issued late op land after full_o rises
    assign lwb.full_o     = (r_count >= FULL_THRESH);
    assign lwb.empty_o    = w_empty;
    assign lwb.iwb_v_o    = w_iwb_v;
    assign lwb.iwb_addr_o = w_head.rd_addr;
    assign lwb.iwb_data_o = w_head.rd_data;
    assign lwb.fwb_v_o    = w_fwb_v;
    assign lwb.fwb_addr_o = w_head.rd_addr;
    assign lwb.fwb_data_o = w_head.rd_data;
    assign lwb.ptw_v_o    = lwb.v_i & lwb.ptw_w_v_i;
    assign lwb.ptw_data_o = lwb.rd_data_i;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(lwb.iwb_yumi_i && !w_iwb_v));
            assert (!(lwb.fwb_yumi_i && !w_fwb_v));
            assert (!(w_enq && (r_count == CNT_FULL)));
            assert (!(w_iwb_v && w_fwb_v));
        end
    end

endmodule

// File: tb/tb_bp_be_late_wb_queue.sv
// Bench for bp_be_late_wb_queue: directed packets, scoreboard of expected drain order
// consumed by a monitor that also acts as the regfile consumer.
module tb_bp_be_late_wb_queue;

    logic clk = 1'b0;
    logic reset_i;
    always #5 clk = ~clk;

    bp_be_late_wb_queue_if #(.data_width_p(66), .addr_width_p(5)) bus();

    bp_be_late_wb_queue #(
        .els_p        (4),
        .data_width_p (66),
        .addr_width_p (5),
        .full_slack_p (1)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .lwb     (bus)
    );

    typedef struct {
        bit          fp;
        logic [4:0]  addr;
        logic [65:0] data;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    bit   drain_en = 1'b0;

    task automatic check(input string nm, input logic [65:0] act, input logic [65:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input bit fp, input logic [4:0] a, input logic [65:0] d);
        exp_t e;
        e.fp = fp; e.addr = a; e.data = d;
        sb.push_back(e);
    endtask

    task automatic idle_in();
        bus.v_i = 1'b0; bus.ird_w_v_i = 1'b0; bus.frd_w_v_i = 1'b0; bus.ptw_w_v_i = 1'b0;
        bus.rd_addr_i = '0; bus.rd_data_i = '0;
    endtask

    task automatic drive(input bit ird, input bit frd, input bit ptw,
                         input logic [4:0] a, input logic [65:0] d);
        bus.v_i = 1'b1; bus.ird_w_v_i = ird; bus.frd_w_v_i = frd; bus.ptw_w_v_i = ptw;
        bus.rd_addr_i = a; bus.rd_data_i = d;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send(input bit ird, input bit frd, input logic [4:0] a, input logic [65:0] d);
        drive(ird, frd, 1'b0, a, d);
        step();
        idle_in();
    endtask

    task automatic wait_drain(input int max_cycles, input string nm);
        bit done = 1'b0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            @(posedge clk); #2;
            if (sb.size() == 0 && bus.empty_o === 1'b1) done = 1'b1;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s: drain timeout, %0d entries still expected", nm, sb.size());
        end
        drain_en = 1'b0;
    endtask

    // Consumer: compares the presented head with the scoreboard and accepts it
    always @(negedge clk) begin
        exp_t e;
        bus.iwb_yumi_i = 1'b0;
        bus.fwb_yumi_i = 1'b0;
        if (drain_en && !reset_i && (bus.iwb_v_o || bus.fwb_v_o)) begin
            check("mon_one_hot", bus.iwb_v_o & bus.fwb_v_o, 0);
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL mon_unexpected: got entry addr %0h expected none", bus.iwb_addr_o);
            end else begin
                e = sb.pop_front();
                check("mon_kind_fp", bus.fwb_v_o, e.fp);
                if (bus.iwb_v_o) begin
                    check("mon_iwb_addr", bus.iwb_addr_o, e.addr);
                    check("mon_iwb_data", bus.iwb_data_o, e.data);
                    bus.iwb_yumi_i = 1'b1;
                end else begin
                    check("mon_fwb_addr", bus.fwb_addr_o, e.addr);
                    check("mon_fwb_data", bus.fwb_data_o, e.data);
                    bus.fwb_yumi_i = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_in();
        reset_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset_i = 1'b0;

        // Reset / idle
        @(negedge clk);
        check("rst_empty", bus.empty_o, 1);
        check("rst_full", bus.full_o, 0);
        check("rst_iwb_v", bus.iwb_v_o, 0);
        check("rst_fwb_v", bus.fwb_v_o, 0);
        step();

        // Single int packet: visible one cycle later, gone after yumi
        drain_en = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 5'd5, 66'h1234);
        push(1'b0, 5'd5, 66'h1234);
        @(negedge clk);
        check("lat_no_bypass", bus.iwb_v_o, 0);
        step();
        idle_in();
        @(negedge clk);
        check("lat_iwb_v", bus.iwb_v_o, 1);
        check("lat_iwb_addr", bus.iwb_addr_o, 5);
        check("lat_iwb_data", bus.iwb_data_o, 66'h1234);
        step();
        @(negedge clk);
        check("lat_empty_after", bus.empty_o, 1);
        check("lat_iwb_v_after", bus.iwb_v_o, 0);
        drain_en = 1'b0;
        step();

        // Ordering int3, fp7, int9 with yumi held low
        send(1'b1, 1'b0, 5'd3, 66'h33);  push(1'b0, 5'd3, 66'h33);
        send(1'b0, 1'b1, 5'd7, 66'h77);  push(1'b1, 5'd7, 66'h77);
        send(1'b1, 1'b0, 5'd9, 66'h99);  push(1'b0, 5'd9, 66'h99);
        @(negedge clk);
        check("ord_head_iwb_v", bus.iwb_v_o, 1);
        check("ord_head_fwb_v", bus.fwb_v_o, 0);
        check("ord_head_addr", bus.iwb_addr_o, 3);
        step();
        @(negedge clk);
        check("ord_head_held", bus.iwb_addr_o, 3);
        drain_en = 1'b1;
        wait_drain(20, "ord_drain");

        // Fill to full threshold, then enqueue and dequeue together across tail wrap
        step();
        send(1'b1, 1'b0, 5'd10, 66'hA0); push(1'b0, 5'd10, 66'hA0);
        send(1'b1, 1'b0, 5'd11, 66'hB1); push(1'b0, 5'd11, 66'hB1);
        @(negedge clk);
        check("fill2_full", bus.full_o, 0);
        step();
        send(1'b0, 1'b1, 5'd12, 66'hC2); push(1'b1, 5'd12, 66'hC2);
        @(negedge clk);
        check("fill3_full", bus.full_o, 1);
        check("fill3_empty", bus.empty_o, 0);
        step();
        drain_en = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 5'd13, 66'h3_0000_0000_0000_00D3);
        push(1'b0, 5'd13, 66'h3_0000_0000_0000_00D3);
        step();
        drain_en = 1'b0;
        idle_in();
        @(negedge clk);
        check("simul_full", bus.full_o, 1);
        check("simul_head", bus.iwb_addr_o, 11);
        step();
        send(1'b0, 1'b1, 5'd14, 66'hE4); push(1'b1, 5'd14, 66'hE4);
        @(negedge clk);
        check("four_full", bus.full_o, 1);
        drain_en = 1'b1;
        wait_drain(30, "wrap_drain");

        // PTW bypass and dropped packets
        step();
        drive(1'b0, 1'b0, 1'b1, 5'd0, 66'hABC);
        #1;
        check("ptw_v", bus.ptw_v_o, 1);
        check("ptw_data", bus.ptw_data_o, 66'hABC);
        check("ptw_iwb_v", bus.iwb_v_o, 0);
        step();
        idle_in();
        @(negedge clk);
        check("ptw_not_enq", bus.empty_o, 1);
        check("ptw_v_idle", bus.ptw_v_o, 0);
        step();
        bus.ptw_w_v_i = 1'b1;
        #1;
        check("ptw_needs_v", bus.ptw_v_o, 0);
        idle_in();
        send(1'b0, 1'b0, 5'd4, 66'h77);
        @(negedge clk);
        check("drop_noflag", bus.empty_o, 1);
        step();

        // Reset mid-operation discards held entries
        send(1'b1, 1'b0, 5'd20, 66'h200);
        send(1'b0, 1'b1, 5'd21, 66'h210);
        @(negedge clk);
        check("pre_rst_empty", bus.empty_o, 0);
        step();
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        @(negedge clk);
        check("mid_rst_empty", bus.empty_o, 1);
        check("mid_rst_iwb_v", bus.iwb_v_o, 0);
        check("mid_rst_fwb_v", bus.fwb_v_o, 0);
        check("mid_rst_full", bus.full_o, 0);
        step();
        send(1'b1, 1'b0, 5'd22, 66'h2_FFFF_FFFF_FFFF_FFFF);
        push(1'b0, 5'd22, 66'h2_FFFF_FFFF_FFFF_FFFF);
        drain_en = 1'b1;
        wait_drain(20, "post_rst_drain");

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
